// File: rtl/draw_engine_pkg.sv
// draw_engine_pkg: screen/grid constants, memory_select and sprite encodings, FSM states
package draw_engine_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int TILE_COLS = 20;
  localparam int TILE_ROWS = 15;
  localparam int TILE_COUNT = TILE_COLS * TILE_ROWS;
  localparam int BG_PIXELS = SCREEN_W * SCREEN_H;
  localparam logic [2:0] TRANSPARENT_COLOUR = 3'b101;
  localparam logic [2:0] SPR_P1 = 3'd6;
  localparam logic [2:0] SPR_P2 = 3'd7;
  typedef enum logic [1:0] {MS_TITLE, MS_STAGE, MS_WIN, MS_BLOCK} mem_sel_e;
  typedef enum logic [2:0] {S_IDLE, S_TILE_FETCH, S_BG_RUN, S_BLK_RUN, S_FLUSH, S_DONE} state_e;
  function automatic logic [7:0] tile_x(input logic [8:0] idx);
    logic [8:0] c;
    c = idx % 9'(TILE_COLS);
    return 8'({c, 3'b000});
  endfunction
  function automatic logic [6:0] tile_y(input logic [8:0] idx);
    logic [8:0] r;
    r = idx / 9'(TILE_COLS);
    return 7'({r, 3'b000});
  endfunction
endpackage

// File: rtl/draw_engine_if.sv
// draw_engine_if: controller, ROM and VGA pixel signals of the draw engine
interface draw_engine_if;
  logic copy_enable;
  logic [1:0] memory_select;
  logic draw_t, draw_p1, draw_p2;
  logic tc_enable, stage_reset;
  logic [7:0] p1_x, p2_x;
  logic [6:0] p1_y, p2_y;
  logic [14:0] bg_addr;
  logic [1:0] bg_sel;
  logic [2:0] bg_data;
  logic [8:0] stage_addr;
  logic [2:0] stage_data;
  logic [8:0] spr_addr;
  logic [2:0] spr_data;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic vga_plot, finished, all_tiles_drawn;
  modport master (
    output copy_enable, memory_select, draw_t, draw_p1, draw_p2, tc_enable, stage_reset,
           p1_x, p2_x, p1_y, p2_y, bg_data, stage_data, spr_data,
    input  bg_addr, bg_sel, stage_addr, spr_addr, vga_x, vga_y, vga_colour, vga_plot,
           finished, all_tiles_drawn
  );
  modport slave (
    input  copy_enable, memory_select, draw_t, draw_p1, draw_p2, tc_enable, stage_reset,
           p1_x, p2_x, p1_y, p2_y, bg_data, stage_data, spr_data,
    output bg_addr, bg_sel, stage_addr, spr_addr, vga_x, vga_y, vga_colour, vga_plot,
           finished, all_tiles_drawn
  );
endinterface

// File: rtl/draw_engine_tile_counter.sv
// tile_counter: stage tile index 0..299 with wrap, clear and all-drawn flag
module tile_counter
  import draw_engine_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       tc_enable,
  input  logic       stage_reset,
  output logic [8:0] tile_index,
  output logic       all_tiles_drawn
);
  logic [8:0] tile_q, tile_d;
  always_comb tile_d = stage_reset ? 9'd0 : !tc_enable ? tile_q : tile_q == 9'(TILE_COUNT - 1) ? 9'd0 : tile_q + 9'd1;
  always_ff @(posedge clock)
    if (!reset) tile_q <= 9'd0;
    else tile_q <= tile_d;
  assign tile_index = tile_q;
  assign all_tiles_drawn = tile_q == 9'(TILE_COUNT - 1);
endmodule

// File: rtl/draw_engine.sv
// draw_engine: streams a background or one 8x8 block to the VGA pixel port.
// Define TRANSPARENCY_EN to suppress player-sprite pixels of TRANSPARENT_COLOUR.
module draw_engine
  import draw_engine_pkg::*;
(
  input logic clock,
  input logic reset,
  draw_engine_if.slave bus
);
  state_e state_q, state_d;
  logic [14:0] pix_q, pix_d;
  logic [7:0] px_q, px_d, ox_q, ox_d, vx_q, vx_d;
  logic [6:0] py_q, py_d, oy_q, oy_d, vy_q, vy_d;
  logic [1:0] bg_sel_q, bg_sel_d;
  logic [2:0] spr_id_q, spr_id_d;
  logic fetch_q, fetch_d, plot_q, plot_d, plot_ok;
  logic [8:0] tile_index, bx, by;
  tile_counter u_tc (
    .clock, .reset, .tc_enable(bus.tc_enable), .stage_reset(bus.stage_reset),
    .tile_index, .all_tiles_drawn(bus.all_tiles_drawn)
  );
  // 9-bit sums so blocks hanging off the right/bottom edge are detected, not wrapped
  assign bx = {1'b0, ox_q} + {6'd0, pix_q[2:0]};
  assign by = {2'd0, oy_q} + {6'd0, pix_q[5:3]};
  always_comb begin
    state_d = state_q;
    pix_d = pix_q;
    px_d = px_q;
    py_d = py_q;
    ox_d = ox_q;
    oy_d = oy_q;
    vx_d = vx_q;
    vy_d = vy_q;
    bg_sel_d = bg_sel_q;
    spr_id_d = spr_id_q;
    fetch_d = fetch_q;
    plot_d = 1'b0;
    case (state_q)
      S_IDLE: if (bus.copy_enable) begin
        bg_sel_d = bus.memory_select;
        pix_d = 15'd0;
        px_d = 8'd0;
        py_d = 7'd0;
        fetch_d = 1'b0;
        if (bus.memory_select != MS_BLOCK) state_d = S_BG_RUN;
        else if (bus.draw_t || !(bus.draw_p1 || bus.draw_p2)) begin
          state_d = S_TILE_FETCH;
          ox_d = tile_x(tile_index);
          oy_d = tile_y(tile_index);
        end else begin
          state_d = S_BLK_RUN;
          spr_id_d = bus.draw_p1 ? SPR_P1 : SPR_P2;
          ox_d = bus.draw_p1 ? bus.p1_x : bus.p2_x;
          oy_d = bus.draw_p1 ? bus.p1_y : bus.p2_y;
        end
      end
      S_TILE_FETCH: begin
        fetch_d = 1'b1;
        if (fetch_q) begin
          spr_id_d = bus.stage_data;
          state_d = S_BLK_RUN;
        end
      end
      S_BG_RUN: begin
        plot_d = 1'b1;
        vx_d = px_q;
        vy_d = py_q;
        pix_d = pix_q + 15'd1;
        px_d = px_q == 8'(SCREEN_W - 1) ? 8'd0 : px_q + 8'd1;
        py_d = px_q == 8'(SCREEN_W - 1) ? py_q + 7'd1 : py_q;
        if (pix_q == 15'(BG_PIXELS - 1)) state_d = S_FLUSH;
      end
      S_BLK_RUN: begin
        plot_d = bx < 9'(SCREEN_W) && by < 9'(SCREEN_H);
        vx_d = bx[7:0];
        vy_d = by[6:0];
        pix_d = pix_q + 15'd1;
        if (pix_q[5:0] == 6'd63) state_d = S_FLUSH;
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clock)
    if (!reset) begin
      state_q <= S_IDLE;
      pix_q <= 15'd0;
      px_q <= 8'd0;
      py_q <= 7'd0;
      ox_q <= 8'd0;
      oy_q <= 7'd0;
      vx_q <= 8'd0;
      vy_q <= 7'd0;
      bg_sel_q <= 2'd0;
      spr_id_q <= 3'd0;
      fetch_q <= 1'b0;
      plot_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q <= pix_d;
      px_q <= px_d;
      py_q <= py_d;
      ox_q <= ox_d;
      oy_q <= oy_d;
      vx_q <= vx_d;
      vy_q <= vy_d;
      bg_sel_q <= bg_sel_d;
      spr_id_q <= spr_id_d;
      fetch_q <= fetch_d;
      plot_q <= plot_d;
    end
`ifdef TRANSPARENCY_EN
  assign plot_ok = plot_q && !(bg_sel_q == MS_BLOCK && spr_id_q[2:1] == 2'b11 && bus.spr_data == TRANSPARENT_COLOUR);
`else
  assign plot_ok = plot_q;
`endif
  assign bus.vga_plot = plot_ok;
  assign bus.vga_colour = !plot_ok ? 3'd0 : bg_sel_q == MS_BLOCK ? bus.spr_data : bus.bg_data;
  assign bus.vga_x = vx_q;
  assign bus.vga_y = vy_q;
  assign bus.bg_sel = bg_sel_q;
  assign bus.finished = state_q == S_DONE;
  assign bus.bg_addr = state_q == S_BG_RUN ? pix_q : 15'd0;
  assign bus.spr_addr = state_q == S_BLK_RUN ? {spr_id_q, pix_q[5:0]} : 9'd0;
  assign bus.stage_addr = state_q == S_TILE_FETCH ? tile_index : 9'd0;
endmodule

// File: doc/draw_engine.md
Name: draw_engine

Overview:
- Datapath responder to the game control FSM's draw commands.
- On a `copy_enable` request, streams one image into the VGA adapter's pixel interface (x, y, colour, plot):
  - a full 160x120 background (title, stage or win screen), or
  - one 8x8 block (stage tile, player 1 sprite or player 2 sprite).
- Returns a one-cycle `finished` pulse when the image is done.
- Owns the stage tile counter that drives `all_tiles_drawn`.

Parameters:
- `SCREEN_W`, 160, screen width in pixels.
- `SCREEN_H`, 120, screen height in pixels.
- `TILE_COLS`, 20, stage grid columns of 8x8 tiles.
- `TILE_ROWS`, 15, stage grid rows.
- `TRANSPARENT_COLOUR`, 3'b101, sprite key colour (used only with `TRANSPARENCY_EN`).

Ports:
- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-low reset
- `copy_enable`  in  1  draw request, level held by controller
- `memory_select`  in  2  0 title, 1 stage background, 2 win screen, 3 block draw
- `draw_t`, `draw_p1`, `draw_p2`  in  1 each  block type when `memory_select`=3
- `tc_enable`  in  1  advance tile counter
- `stage_reset`  in  1  clear tile counter
- `p1_x`, `p2_x`  in  8  player top-left x (pixels)
- `p1_y`, `p2_y`  in  7  player top-left y (pixels)
- `bg_addr`  out  15  background ROM address, y*160+x
- `bg_sel`  out  2  which background ROM; latched `memory_select`
- `bg_data`  in  3  background colour, valid 1 cycle after address
- `stage_addr`  out  9  stage map address (= `tile_index`)
- `stage_data`  in  3  tile type 0..5, valid 1 cycle after address
- `spr_addr`  out  9  {sprite_id[2:0], row[2:0], col[2:0]}
- `spr_data`  in  3  sprite colour, valid 1 cycle after address
- `vga_x`  out  8  pixel x
- `vga_y`  out  7  pixel y
- `vga_colour`  out  3  pixel colour
- `vga_plot`  out  1  write strobe
- `finished`  out  1  one-cycle completion pulse
- `all_tiles_drawn`  out  1  `tile_index`==299

Behaviour:
- Reset (`reset`=0 at clock edge):
  - state IDLE; `tile_index`=0.
  - `vga_plot`=0, `finished`=0; `vga_x`/`vga_y`/`vga_colour`=0.
  - All address outputs 0; `bg_sel`=0.
  - Takes effect mid-draw too: the draw is abandoned, no `finished` pulse.
- State IDLE:
  - Stays in IDLE while `copy_enable`=0.
  - On `copy_enable`=1, latches mode, clears pixel counter and jumps:
    - `memory_select` 0..2 → BG_RUN.
    - `memory_select`=3 → priority `draw_t` > `draw_p1` > `draw_p2`; none asserted is treated as `draw_t`.
    - Tile → TILE_FETCH; player 1 → BLK_RUN with sprite_id 6; player 2 → BLK_RUN with sprite_id 7.
- TILE_FETCH (2 cycles):
  - Drives `stage_addr`=`tile_index`.
  - Captures `stage_data` as sprite_id.
  - Block origin x = (`tile_index` mod 20)*8, y = (`tile_index` div 20)*8.
  - Then BLK_RUN.
- BG_RUN:
  - Issues `bg_addr` 0..19199, one per cycle, raster order.
  - 19200 cycles, then FLUSH.
- BLK_RUN:
  - Issues 64 `spr_addr` values, row-major, one per cycle, then FLUSH.
  - Player origin is sampled from `p1_*`/`p2_*` at the IDLE accept edge.
- Pipeline:
  - Pixel coordinates are delayed 1 cycle to align with ROM data.
  - `vga_plot` for an address issued in cycle n is asserted in cycle n+1.
- FLUSH (1 cycle): presents the last pixel, then DONE.
- DONE (1 cycle): `finished`=1 → IDLE. DONE never restarts a draw.
- Back-to-back requests: a request held high (e.g. P1 then P2) is re-accepted in IDLE one cycle after the `finished` pulse, with the mode resampled then.
- Latency from the accept edge:
  - `finished` in cycle N+3, where N is 19200 or 64; tile draws add 2.
- Clipping: block pixels with x>159 or y>119 (9-bit sum) are fetched but `vga_plot`=0.
- Inputs ignored while busy: `copy_enable`, `memory_select`, `draw_*`.
- Tile counter:
  - Each `tc_enable` cycle: +1; wraps 299→0.
  - `stage_reset` clears to 0 and has priority over `tc_enable`.
  - `all_tiles_drawn` is combinational from the register.

Optional Feature:
- Macro `TRANSPARENCY_EN`.
- Defined: in player-sprite mode (id 6/7), a pixel whose `spr_data`==`TRANSPARENT_COLOUR` gets `vga_plot`=0. Tiles and backgrounds are unaffected.
- Undefined: every in-bounds pixel is plotted; the parameter is unused.

Decomposition:
- Shared package:
  - screen/grid constants.
  - `memory_select` encodings 0..3.
  - sprite_id constants: tiles 0..5, `SPR_P1`=6, `SPR_P2`=7.
  - state encoding.
- Sub-module `tile_counter`: `tile_index`, wrap, `stage_reset`, `all_tiles_drawn`.

Test Plan:
- Full-screen copy: reset, `copy_enable`=1, `memory_select`=0, ROM returns addr[2:0].
  → 19200 plots in raster order; plot at (159,119) colour 3'b111; `bg_sel`=0; `finished` one pulse, cycle 19203.
- Tile draw: `tile_index`=21, `stage_data`=4, `draw_t`.
  → `spr_addr` 256..319; plots at x 8..15, y 8..15; `finished` cycle 69.
- Back-to-back sprites: `draw_p1` at (152,112), then controller switches to `draw_p2` at (0,0) on `finished`.
  → P1 all 64 in bounds; P2 accepted cycle after pulse; two `finished` pulses.
- Clipping: `draw_p1` at (156,118).
  → only 4x2=8 plots; `finished` still pulses.
- Tile counter: 299 `tc_enable` pulses → `all_tiles_drawn`=1; one more → index 0, flag 0; `stage_reset` together with `tc_enable` → 0.
- Reset mid-draw: `reset`=0 at pixel 5000.
  → next cycle `vga_plot`=0, `finished`=0, state IDLE; no pulse afterwards.
- With `TRANSPARENCY_EN`: sprite ROM returns `TRANSPARENT_COLOUR` for 10 pixels → 54 plots.
